// File: rtl/riscv_pkg.sv
// Shared definitions for the data-memory access path: funct3 encodings,
// controller state and error-cause encodings, and decode helpers.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_FUNCT3   = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_cause_t;

  // Unsigned load sizes have no store counterpart.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    logic mis;
    mis = 1'b0;
    case (f3)
      F3_H, F3_HU: mis = lo[0];
      F3_W:        mis = (lo != 2'b00);
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Data-memory request/acknowledge bus between the LSU controller (master)
// and the data memory (slave).
interface lsu_mem_ctrl_if #(
  parameter int XLEN = 32
) ();
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [3:0]      dmem_be;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/lsu_load_align.sv
// Selects the addressed lane of a read word and sign/zero-extends it
// according to the load size.
module lsu_load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select then extension by load type.
  always_comb begin
    byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      F3_H:    data_o = {{(XLEN-16){half_s[15]}}, half_s};
      F3_W:    data_o = rdata_i;
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_s};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_s};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Data-memory access controller: turns a decoded load/store into a single
// req/ack bus transaction, stalls the core while it is outstanding, formats
// load data and reports misaligned, illegal-size and timeout errors.
module lsu_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] store_data_i,
  output logic            stall_o,
  output logic [XLEN-1:0] load_data_o,
  output logic            load_valid_o,
  output logic            access_err_o,
  output logic [1:0]      err_cause_o,
  lsu_mem_ctrl_if.master  dmem
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WDOG_EN = (TIMEOUT > 0);
  localparam logic [WDW-1:0] WDOG_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;

  lsu_state_t      state_q;
  logic [WDW-1:0]  wdog_q;
  logic            req_q;
  logic            we_q;
  logic [XLEN-1:0] addr_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic [2:0]      f3_q;
  logic [1:0]      lane_q;
  logic            is_load_q;
  logic            timeout_q;
  logic            load_valid_q;
  logic [XLEN-1:0] load_data_q;

  logic            access_s;
  logic            illegal_s;
  logic            mis_s;
  logic            err_s;
  logic [3:0]      be_s;
  logic [XLEN-1:0] wdata_s;
  logic [XLEN-1:0] aligned_s;
  err_cause_t      cause_s;

  // A simultaneous read and write is treated as a store.
  assign access_s  = mem_read_i | mem_write_i;
  assign illegal_s = ~f3_legal(mem_write_i, funct3_i);
  assign mis_s     = misaligned(funct3_i, addr_i[1:0]);
  assign err_s     = illegal_s | mis_s;

  // Store lane placement; loads always request the full word.
  always_comb begin
    be_s    = 4'b1111;
    wdata_s = store_data_i;
    if (mem_write_i) begin
      case (funct3_i)
        F3_B: begin
          be_s    = 4'b0001 << addr_i[1:0];
          wdata_s = {4{store_data_i[7:0]}};
        end
        F3_H: begin
          be_s    = 4'b0011 << addr_i[1:0];
          wdata_s = {2{store_data_i[15:0]}};
        end
        default: begin
          be_s    = 4'b1111;
          wdata_s = store_data_i;
        end
      endcase
    end else begin
      be_s    = 4'b1111;
      wdata_s = store_data_i;
    end
  end

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i   (dmem.dmem_rdata),
    .addr_lo_i (lane_q),
    .funct3_i  (f3_q),
    .data_o    (aligned_s)
  );

  // Stall and error reporting: request errors are flagged in IDLE, timeouts in DONE.
  always_comb begin
    stall_o = 1'b0;
    cause_s = ERR_NONE;
    if (rst) begin
      stall_o = 1'b0;
      cause_s = ERR_NONE;
    end else begin
      case (state_q)
        IDLE: begin
          if (access_s && err_s) begin
            cause_s = illegal_s ? ERR_FUNCT3 : ERR_MISALIGN;
          end else if (access_s) begin
            stall_o = 1'b1;
          end else begin
            stall_o = 1'b0;
          end
        end
        BUSY:    stall_o = 1'b1;
        DONE:    cause_s = timeout_q ? ERR_TIMEOUT : ERR_NONE;
        default: stall_o = 1'b0;
      endcase
    end
  end

  assign err_cause_o  = cause_s;
  assign access_err_o = (cause_s != ERR_NONE);
  assign load_valid_o = load_valid_q;
  assign load_data_o  = load_data_q;

  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = wdata_q;

  // Transaction FSM with watchdog; bus outputs are frozen for the whole of BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wdog_q       <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      be_q         <= 4'b0000;
      wdata_q      <= '0;
      f3_q         <= 3'b000;
      lane_q       <= 2'b00;
      is_load_q    <= 1'b0;
      timeout_q    <= 1'b0;
      load_valid_q <= 1'b0;
      load_data_q  <= '0;
    end else begin
      load_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access_s && !err_s) begin
            state_q   <= BUSY;
            req_q     <= 1'b1;
            we_q      <= mem_write_i;
            addr_q    <= {addr_i[XLEN-1:2], 2'b00};
            be_q      <= be_s;
            wdata_q   <= wdata_s;
            f3_q      <= funct3_i;
            lane_q    <= addr_i[1:0];
            is_load_q <= ~mem_write_i;
            wdog_q    <= '0;
          end
        end
        BUSY: begin
          if (dmem.dmem_ack) begin
            state_q <= DONE;
            req_q   <= 1'b0;
            if (is_load_q) begin
              load_data_q  <= aligned_s;
              load_valid_q <= 1'b1;
            end
          end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
            state_q   <= DONE;
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            if (is_load_q) begin
              load_data_q  <= '0;
              load_valid_q <= 1'b1;
            end
          end else begin
            wdog_q <= wdog_q + WDW'(1);
          end
        end
        DONE:    state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: a default-timeout instance carries the
// main traffic, a TIMEOUT=4 instance shares the core inputs for the watchdog test.
module tb_lsu_mem_ctrl;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;

  logic        stall, load_valid, access_err;
  logic [31:0] load_data;
  logic [1:0]  err_cause;
  logic        stall4, load_valid4, access_err4;
  logic [31:0] load_data4;
  logic [1:0]  err_cause4;

  lsu_mem_ctrl_if #(.XLEN(32)) bus ();
  lsu_mem_ctrl_if #(.XLEN(32)) bus4 ();

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_wdata_q[$];
  logic [3:0]  exp_be_q[$];
  logic [31:0] exp_load_q[$];
  logic [31:0] last_load;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_mem_ctrl #(.XLEN(32), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .funct3_i(funct3), .addr_i(addr), .store_data_i(store_data),
    .stall_o(stall), .load_data_o(load_data), .load_valid_o(load_valid),
    .access_err_o(access_err), .err_cause_o(err_cause), .dmem(bus)
  );

  lsu_mem_ctrl #(.XLEN(32), .TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .rst(rst), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .funct3_i(funct3), .addr_i(addr), .store_data_i(store_data),
    .stall_o(stall4), .load_data_o(load_data4), .load_valid_o(load_valid4),
    .access_err_o(access_err4), .err_cause_o(err_cause4), .dmem(bus4)
  );

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0;
    bus.dmem_ack = 1'b0; bus.dmem_rdata = 32'h0;
    bus4.dmem_ack = 1'b0; bus4.dmem_rdata = 32'h0;
    last_load = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({stall, load_valid, access_err, err_cause, bus.dmem_req, bus.dmem_we, bus.dmem_be} !== 10'b0 ||
        load_data !== 32'h0 || bus.dmem_addr !== 32'h0 || bus.dmem_wdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset: stall=%b req=%b lv=%b err=%b cause=%0d ld=%h, want all 0",
               stall, bus.dmem_req, load_valid, access_err, err_cause, load_data);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (stall !== 1'b0 || bus.dmem_req !== 1'b0 || load_valid !== 1'b0 || access_err !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: stall=%b req=%b lv=%b err=%b, want 0", stall, bus.dmem_req, load_valid, access_err);
    end
  endtask

  // One legal access on the main instance; ack arrives in BUSY cycle 'dly' (0 = first).
  task automatic do_access(input string name, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                           input int dly, input logic [3:0] ebe, input logic [31:0] ewd,
                           input logic [31:0] eld);
    logic [31:0] xa, xw, xl;
    logic [3:0]  xb;
    logic        is_ld;
    is_ld = rd & ~wr;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    exp_addr_q.push_back(a & 32'hFFFF_FFFC);
    exp_be_q.push_back(ebe);
    exp_wdata_q.push_back(ewd);
    if (is_ld) exp_load_q.push_back(eld);
    @(negedge clk);
    n_vec++;
    if (stall !== 1'b1 || bus.dmem_req !== 1'b0 || access_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s idle: stall=%b req=%b err=%b, want 1 0 0", name, stall, bus.dmem_req, access_err);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    xa = exp_addr_q.pop_front();
    xb = exp_be_q.pop_front();
    xw = exp_wdata_q.pop_front();
    for (int i = 0; i <= dly; i++) begin
      if (i == dly) begin
        bus.dmem_ack = 1'b1; bus.dmem_rdata = rdat;
        bus4.dmem_ack = 1'b1; bus4.dmem_rdata = rdat;
      end else begin
        bus.dmem_rdata = 32'h0BAD_0BAD; bus4.dmem_rdata = 32'h0BAD_0BAD;
      end
      @(negedge clk);
      n_vec++;
      if (stall !== 1'b1 || bus.dmem_req !== 1'b1 || bus.dmem_we !== wr || bus.dmem_addr !== xa ||
          bus.dmem_be !== xb || (wr && bus.dmem_wdata !== xw)) begin
        n_err++;
        $display("FAIL %s busy%0d: stall=%b req=%b we=%b addr=%h be=%b wd=%h, want 1 1 %b %h %b %h",
                 name, i, stall, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be,
                 bus.dmem_wdata, wr, xa, xb, xw);
      end
      @(posedge clk); #1;
      bus.dmem_ack = 1'b0; bus4.dmem_ack = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if (stall !== 1'b0 || bus.dmem_req !== 1'b0 || load_valid !== is_ld || access_err !== 1'b0) begin
      n_err++;
      $display("FAIL %s done: stall=%b req=%b lv=%b err=%b, want 0 0 %b 0",
               name, stall, bus.dmem_req, load_valid, access_err, is_ld);
    end
    if (is_ld) begin
      xl = exp_load_q.pop_front();
      last_load = xl;
      n_vec++;
      if (load_data !== xl) begin
        n_err++;
        $display("FAIL %s data: load_data=%h, want %h", name, load_data, xl);
      end
    end
  endtask

  task automatic test_loads();
    do_access("lw",    1'b1, 1'b0, F3_W,  32'h100, 32'h0, 32'hDEADBEEF, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
    do_access("lb",    1'b1, 1'b0, F3_B,  32'h103, 32'h0, 32'h80123456, 0, 4'b1111, 32'h0, 32'hFFFFFF80);
    do_access("lbu",   1'b1, 1'b0, F3_BU, 32'h103, 32'h0, 32'h80123456, 0, 4'b1111, 32'h0, 32'h00000080);
    do_access("lh",    1'b1, 1'b0, F3_H,  32'h102, 32'h0, 32'h80015555, 1, 4'b1111, 32'h0, 32'hFFFF8001);
    do_access("lhu",   1'b1, 1'b0, F3_HU, 32'h100, 32'h0, 32'h12348765, 2, 4'b1111, 32'h0, 32'h00008765);
  endtask

  task automatic test_stores();
    do_access("sh",    1'b0, 1'b1, F3_H,  32'h202, 32'h1234ABCD, 32'h0, 5, 4'b1100, 32'hABCDABCD, 32'h0);
    do_access("sb",    1'b0, 1'b1, F3_B,  32'h101, 32'h000000A5, 32'h0, 1, 4'b0010, 32'hA5A5A5A5, 32'h0);
    do_access("rw_sw", 1'b1, 1'b1, F3_W,  32'h400, 32'hCAFEF00D, 32'h0, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
  endtask

  task automatic test_back_to_back();
    do_access("b2b_lb", 1'b1, 1'b0, F3_B, 32'h101, 32'h0, 32'h00007F00, 0, 4'b1111, 32'h0, 32'h0000007F);
    do_access("b2b_sw", 1'b0, 1'b1, F3_W, 32'h104, 32'h01020304, 32'h0, 0, 4'b1111, 32'h01020304, 32'h0);
  endtask

  task automatic test_errors();
    logic [1:0] ec [7];
    logic [2:0] ef [7];
    logic [31:0] ea [7];
    logic [1:0] erw [7];
    ef = '{F3_W, 3'b011, F3_H, F3_W, 3'b100, 3'b011, 3'b110};
    ea = '{32'h101, 32'h100, 32'h103, 32'h102, 32'h100, 32'h101, 32'h100};
    erw = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10, 2'b10};
    ec = '{2'd1, 2'd2, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
      mem_read = erw[k][1]; mem_write = erw[k][0]; funct3 = ef[k]; addr = ea[k];
      @(negedge clk);
      n_vec++;
      if (access_err !== 1'b1 || err_cause !== ec[k] || stall !== 1'b0 || bus.dmem_req !== 1'b0) begin
        n_err++;
        $display("FAIL err%0d: err=%b cause=%0d stall=%b req=%b, want 1 %0d 0 0",
                 k, access_err, err_cause, stall, bus.dmem_req, ec[k]);
      end
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.dmem_req !== 1'b0 || stall !== 1'b0 || access_err !== 1'b0 || load_data !== last_load) begin
        n_err++;
        $display("FAIL err%0d_after: req=%b stall=%b err=%b ld=%h, want 0 0 0 %h",
                 k, bus.dmem_req, stall, access_err, load_data, last_load);
      end
    end
  endtask

  task automatic test_timeout();
    @(posedge clk); #1;
    mem_read = 1'b1; funct3 = F3_W; addr = 32'h300;
    @(negedge clk);
    n_vec++;
    if (stall4 !== 1'b1 || load_data4 !== 32'h0000007F) begin
      n_err++;
      $display("FAIL to_idle: stall=%b ld=%h, want 1 0000007f", stall4, load_data4);
    end
    @(posedge clk); #1;
    mem_read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (bus4.dmem_req !== 1'b1 || stall4 !== 1'b1 || access_err4 !== 1'b0) begin
        n_err++;
        $display("FAIL to_busy%0d: req=%b stall=%b err=%b, want 1 1 0", i, bus4.dmem_req, stall4, access_err4);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_vec++;
    if (access_err4 !== 1'b1 || err_cause4 !== 2'd3 || load_data4 !== 32'h0 ||
        stall4 !== 1'b0 || bus4.dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL to_done: err=%b cause=%0d ld=%h stall=%b req=%b, want 1 3 0 0 0",
               access_err4, err_cause4, load_data4, stall4, bus4.dmem_req);
    end
    @(posedge clk); #1;
    bus4.dmem_ack = 1'b1; bus4.dmem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    n_vec++;
    if (bus4.dmem_req !== 1'b0 || load_valid4 !== 1'b0 || access_err4 !== 1'b0 || stall4 !== 1'b0) begin
      n_err++;
      $display("FAIL to_stray: req=%b lv=%b err=%b stall=%b, want 0", bus4.dmem_req, load_valid4, access_err4, stall4);
    end
    @(posedge clk); #1;
    bus4.dmem_ack = 1'b0;
    @(negedge clk);
    n_vec++;
    if (load_valid4 !== 1'b0 || load_data4 !== 32'h0 || bus4.dmem_req !== 1'b0) begin
      n_err++;
      $display("FAIL to_stray2: lv=%b ld=%h req=%b, want 0 0 0", load_valid4, load_data4, bus4.dmem_req);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    n_vec++;
    if (bus.dmem_req !== 1'b1 || stall !== 1'b1) begin
      n_err++;
      $display("FAIL rst_pre: req=%b stall=%b, want 1 1", bus.dmem_req, stall);
    end
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.dmem_req !== 1'b0 || stall !== 1'b0 || load_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid: req=%b stall=%b lv=%b, want 0 0 0", bus.dmem_req, stall, load_valid);
    end
    @(posedge clk); #1;
    bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    n_vec++;
    if (bus.dmem_req !== 1'b0 || load_valid !== 1'b0 || load_data !== 32'h0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL rst_late_ack: req=%b lv=%b ld=%h stall=%b, want 0 0 0 0",
               bus.dmem_req, load_valid, load_data, stall);
    end
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    do_access("post_rst_sw", 1'b0, 1'b1, F3_W, 32'h500, 32'h55AA33CC, 32'h0, 0, 4'b1111, 32'h55AA33CC, 32'h0);
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_back_to_back();
    test_errors();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Data-memory access controller for the RISC-V core; the consumer of the main decoder's mem_read / mem_write / mem_to_reg controls.
- Converts a decoded load or store into a req/ack transaction on the data-memory bus.
- Stalls the core while the transaction is outstanding.
- Returns the aligned, sign- or zero-extended load value and flags access errors.

Parameters:
- XLEN, 32, data and address width.
- TIMEOUT, 16, maximum cycles to wait for mem_ack before a bus error; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_read  in  1  load decoded this cycle.
- mem_write  in  1  store decoded this cycle.
- funct3  in  3  access size and signedness.
- addr  in  XLEN  effective address (ALU result).
- store_data  in  XLEN  rs2 value.
- stall  out  1  hold PC and pipeline state.
- load_data  out  XLEN  formatted load result.
- load_valid  out  1  load_data valid this cycle.
- access_err  out  1  one-cycle error pulse.
- err_cause  out  2  0 none, 1 misaligned, 2 illegal funct3, 3 timeout.
- dmem_req  out  1  bus request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  XLEN  word-aligned address (addr[1:0] = 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-positioned store data.
- dmem_rdata  in  XLEN  read data.
- dmem_ack  in  1  completes the request; 1-cycle pulse.

Behaviour:
- Reset: state IDLE, watchdog counter 0. All outputs are 0, including stall, dmem_req, load_data, load_valid, access_err and err_cause. rst mid-transaction drops dmem_req on the next edge; a late dmem_ack is ignored.
- States: IDLE, BUSY, DONE.
- access = mem_read | mem_write. Both high means store; mem_read is ignored.
- funct3 for loads: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Any other value is illegal.
- funct3 for stores: 000 sb, 001 sh, 010 sw. Any other value is illegal.
- Misaligned: half access with addr[0] = 1, or word access with addr[1:0] != 0.
- IDLE with access and an error condition:
  - access_err = 1 combinationally, with err_cause set; illegal funct3 takes priority over misaligned.
  - stall = 0, no bus request, state stays IDLE.
- IDLE with a legal access:
  - stall = 1 combinationally.
  - On the edge, register dmem_addr, dmem_we, dmem_be, dmem_wdata and the load format; go to BUSY.
- BUSY:
  - dmem_req = 1 and stall = 1.
  - Registered bus outputs are held stable until ack.
  - The watchdog increments each cycle.
- BUSY with dmem_ack:
  - Load: capture and format dmem_rdata into load_data.
  - Go to DONE; dmem_req falls on that edge.
- BUSY with no ack after TIMEOUT cycles in BUSY:
  - Go to DONE with err_cause 3.
  - access_err pulses in DONE; load_data = 0.
- DONE:
  - stall = 0.
  - load_valid = 1 for loads.
  - access_err pulses if a timeout occurred.
  - Unconditional return to IDLE; access inputs are ignored in DONE. The core advances on this edge.
- Latency: a load with ack on the first BUSY cycle gives stall for 2 cycles (IDLE, BUSY), and data in cycle 3.
- load_data holds its last value between loads. load_valid is a strobe.
- Byte enables:
  - sb: 0001 << addr[1:0], wdata = byte replicated ×4.
  - sh: 0011 << addr[1:0], wdata = half replicated ×2.
  - sw: 1111.
  - Loads: 1111, ignored by memory.
- Load format: select the lane by registered addr[1:0], then sign-extend (lb, lh) or zero-extend (lbu, lhu).
- dmem_ack outside BUSY is ignored.
- Watchdog clears on entering BUSY. With TIMEOUT = 0 the block waits forever.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 size constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - lsu_state_t enum {IDLE, BUSY, DONE}.
  - err_cause_t enum.
- One combinational sub-module lsu_load_align takes rdata, addr[1:0] and funct3 and produces the extended XLEN result. The FSM, watchdog and store lane logic stay in lsu_mem_ctrl.

Test Plan:
- lw addr 0x100, ack the cycle after req, rdata 0xDEADBEEF:
  - stall high 2 cycles.
  - dmem_addr 0x100, be 1111.
  - load_data 0xDEADBEEF with load_valid in cycle 3.
- lb and lbu addr 0x103, rdata 0x80xxxxxx: load_data 0xFFFFFF80 (lb) and 0x00000080 (lbu).
- sh addr 0x202, data 0x1234ABCD, ack delayed 5 cycles:
  - be 1100, wdata 0xABCDABCD.
  - dmem_req and outputs stable 6 cycles.
  - stall released in DONE.
- lw addr 0x101: access_err = 1, cause 1, no dmem_req, stall 0. Load with funct3 011: cause 2.
- TIMEOUT = 4, no ack: req for 4 cycles, then DONE with access_err and cause 3, load_data 0; a later stray ack is ignored.
- rst asserted during BUSY: next cycle dmem_req = 0 and stall = 0; subsequent sw completes normally.
